// File: rtl/fht_but_pipe.sv
// Three-stage radix-2 Hartley butterfly with valid/ready flow control, coefficient
// rounding, optional /2 output scaling, saturation and a sticky overflow status.
module fht_but_pipe #(
    parameter int D_BIT   = 17,
    parameter int W_BIT   = 12,
    parameter int W_HALF  = 512,
    parameter int CNT_BIT = 16
) (
    input  logic                    iCLK,
    input  logic                    iRESET,
    input  logic                    iVALID,
    output logic                    oREADY,
    input  logic signed [D_BIT-1:0] iX_0,
    input  logic signed [D_BIT-1:0] iX_1,
    input  logic signed [D_BIT-1:0] iX_2,
    input  logic signed [W_BIT-1:0] iSIN,
    input  logic signed [W_BIT-1:0] iCOS,
    input  logic                    iSCALE,
    output logic                    oVALID,
    input  logic                    iREADY,
    output logic signed [D_BIT-1:0] oY_0,
    output logic signed [D_BIT-1:0] oY_1,
    output logic                    oOVF,
    output logic [CNT_BIT-1:0]      oOVF_CNT,
    input  logic                    iCLR_OVF
);

    localparam int P_W = D_BIT + W_BIT;
    localparam int A_W = P_W + 1;
    localparam int T_W = D_BIT + 3;
    localparam int S_W = D_BIT + 4;
    localparam logic signed [A_W-1:0] RND     = A_W'(W_HALF);
    localparam logic signed [S_W-1:0] SAT_MAX = S_W'((2 ** (D_BIT - 1)) - 1);
    localparam logic signed [S_W-1:0] SAT_MIN = S_W'(-(2 ** (D_BIT - 1)));

    function automatic logic signed [T_W-1:0] f_round(input logic signed [P_W-1:0] a,
                                                      input logic signed [P_W-1:0] b);
        logic signed [A_W-1:0] sum;
        sum = A_W'(a) + A_W'(b) + RND;
        return T_W'(sum >>> (W_BIT - 2));
    endfunction

    function automatic logic signed [S_W-1:0] f_scale(input logic signed [S_W-1:0] s,
                                                      input logic sc);
        return sc ? ((s + S_W'(1)) >>> 1) : s;
    endfunction

    function automatic logic f_ovf(input logic signed [S_W-1:0] s);
        return (s > SAT_MAX) || (s < SAT_MIN);
    endfunction

    function automatic logic signed [D_BIT-1:0] f_sat(input logic signed [S_W-1:0] s);
        if (s > SAT_MAX) return D_BIT'(SAT_MAX);
        if (s < SAT_MIN) return D_BIT'(SAT_MIN);
        return D_BIT'(s);
    endfunction

    logic                    w_adv;
    logic                    w_load;
    logic                    w_ovf_evt;
    logic signed [P_W-1:0]   w_pc;
    logic signed [P_W-1:0]   w_ps;
    logic signed [S_W-1:0]   w_s0_p1;
    logic signed [S_W-1:0]   w_s1_p1;

    logic                    r_vld_p0;
    logic                    r_vld_p1;
    logic signed [P_W-1:0]   r_pc_p0;
    logic signed [P_W-1:0]   r_ps_p0;
    logic signed [D_BIT-1:0] r_x0_p0;
    logic                    r_scl_p0;
    logic signed [T_W-1:0]   r_t_p1;
    logic signed [D_BIT-1:0] r_x0_p1;
    logic                    r_scl_p1;

    assign w_adv  = ~oVALID | iREADY;
    assign oREADY = w_adv;
    assign w_load = w_adv & r_vld_p1;

    assign w_pc = P_W'(iX_1) * P_W'(iCOS);
    assign w_ps = P_W'(iX_2) * P_W'(iSIN);

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
            oVALID   <= 1'b0;
        end else if (w_adv) begin
            r_vld_p0 <= iVALID;
            r_vld_p1 <= r_vld_p0;
            oVALID   <= r_vld_p1;
        end
    end

    // Stage 1: products, x0 and scale flag
    always_ff @(posedge iCLK) begin
        if (w_adv && iVALID) begin
            r_pc_p0  <= w_pc;
            r_ps_p0  <= w_ps;
            r_x0_p0  <= iX_0;
            r_scl_p0 <= iSCALE;
        end
    end

    // Stage 2: rounded rotation term t
    always_ff @(posedge iCLK) begin
        if (w_adv && r_vld_p0) begin
            r_t_p1   <= f_round(r_pc_p0, r_ps_p0);
            r_x0_p1  <= r_x0_p0;
            r_scl_p1 <= r_scl_p0;
        end
    end

    // Stage 3: sum/difference, optional halving, saturation into the output register
    assign w_s0_p1   = f_scale(S_W'(r_x0_p1) + S_W'(r_t_p1), r_scl_p1);
    assign w_s1_p1   = f_scale(S_W'(r_x0_p1) - S_W'(r_t_p1), r_scl_p1);
    assign w_ovf_evt = w_load & (f_ovf(w_s0_p1) | f_ovf(w_s1_p1));

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            oY_0 <= '0;
            oY_1 <= '0;
        end else if (w_load) begin
            oY_0 <= f_sat(w_s0_p1);
            oY_1 <= f_sat(w_s1_p1);
        end
    end

    // A clear coinciding with an overflowing load keeps that one event.
    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            oOVF     <= 1'b0;
            oOVF_CNT <= '0;
        end else if (iCLR_OVF) begin
            oOVF     <= w_ovf_evt;
            oOVF_CNT <= CNT_BIT'(w_ovf_evt);
        end else if (w_ovf_evt) begin
            oOVF <= 1'b1;
            if (oOVF_CNT != '1) oOVF_CNT <= oOVF_CNT + CNT_BIT'(1);
        end
    end

endmodule
